// File: rtl/i2c_clock_generator.sv
// i2c_clock_generator: divider-derived SCL with mid-phase strobes; I2C_CLOCK_STRETCH_EN adds slave clock stretching
module i2c_clock_generator #(
  parameter int BAUD_WIDTH = 20,
  parameter int FREQ_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [BAUD_WIDTH-1:0] BaudRate,
  input  logic [FREQ_WIDTH-1:0] ClockFrequency,
  input  logic                  StretchIn,
  output logic                  ClockOut,
  output logic                  MidHighStrobe,
  output logic                  MidLowStrobe,
  output logic                  Running,
  output logic                  ConfigError
);
  localparam int IW = $clog2(FREQ_WIDTH);
  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;
  state_t state, state_nxt;
  logic [FREQ_WIDTH-1:0] dq, counter, q_next;
  logic [BAUD_WIDTH:0] divisor, rem, diff;
  logic [BAUD_WIDTH+1:0] trial;
  logic [IW-1:0] iter;
  logic qbit, last, start, toggle_pt, mid, stall;
  // dq shifts the dividend out and the quotient in; after the last step it is HalfCount
  assign trial = {rem, dq[FREQ_WIDTH-1]};
  assign qbit = trial >= {1'b0, divisor};
  assign diff = trial[BAUD_WIDTH:0] - divisor;
  assign q_next = {dq[FREQ_WIDTH-2:0], qbit};
  assign last = iter == IW'(FREQ_WIDTH - 1);
  assign start = Enable && !ConfigError && BaudRate != '0;
  assign toggle_pt = counter == dq - FREQ_WIDTH'(1);
  assign mid = counter == (dq >> 1) - FREQ_WIDTH'(1);
  assign Running = state == RUN;
`ifdef I2C_CLOCK_STRETCH_EN
  logic [1:0] sync;
  always_ff @(posedge clock) sync <= !Reset ? 2'b11 : {sync[0], StretchIn};
  assign stall = toggle_pt && ClockOut && dq >= FREQ_WIDTH'(3) && !sync[1];
`else
  logic unused_stretch;
  assign unused_stretch = StretchIn;
  assign stall = 1'b0;
`endif
  always_comb begin
    state_nxt = !Enable ? IDLE :
                state == IDLE ? (start ? DIVIDE : IDLE) :
                state == DIVIDE ? (last ? (q_next < FREQ_WIDTH'(2) ? IDLE : RUN) : DIVIDE) :
                state == RUN ? RUN : IDLE;
  end
  always_ff @(posedge clock) state <= !Reset ? IDLE : state_nxt;
  always_ff @(posedge clock) begin
    if (!Reset) begin
      dq <= '0;
      counter <= '0;
      divisor <= '0;
      rem <= '0;
      iter <= '0;
      ClockOut <= 1'b1;
      MidHighStrobe <= 1'b0;
      MidLowStrobe <= 1'b0;
      ConfigError <= 1'b0;
    end else if (!Enable) begin
      ConfigError <= 1'b0;
      ClockOut <= 1'b1;
      counter <= '0;
      MidHighStrobe <= 1'b0;
      MidLowStrobe <= 1'b0;
    end else if (state == IDLE) begin
      if (BaudRate == '0) ConfigError <= 1'b1;
      if (start) begin
        dq <= ClockFrequency;
        divisor <= {BaudRate, 1'b0};
        rem <= '0;
        iter <= '0;
      end
    end else if (state == DIVIDE) begin
      dq <= q_next;
      rem <= qbit ? diff : trial[BAUD_WIDTH:0];
      iter <= iter + IW'(1);
      if (last && q_next < FREQ_WIDTH'(2)) ConfigError <= 1'b1;
      counter <= '0;
      ClockOut <= 1'b1;
    end else if (!stall) begin
      counter <= toggle_pt ? '0 : counter + FREQ_WIDTH'(1);
      ClockOut <= toggle_pt ? ~ClockOut : ClockOut;
      MidHighStrobe <= mid && ClockOut;
      MidLowStrobe <= mid && !ClockOut;
    end
  end
endmodule

// File: tb/tb_i2c_clock_generator.sv
// tb_i2c_clock_generator: directed checks of divider timing, SCL/strobe waveform, errors, aborts and stretching
module tb_i2c_clock_generator;
  logic clock = 1'b0;
  logic Reset, Enable, StretchIn;
  logic [19:0] BaudRate;
  logic [29:0] ClockFrequency;
  logic ClockOut, MidHighStrobe, MidLowStrobe, Running, ConfigError;
  int checks = 0;
  int errors = 0;

  i2c_clock_generator dut (
    .clock(clock), .Reset(Reset), .Enable(Enable), .BaudRate(BaudRate),
    .ClockFrequency(ClockFrequency), .StretchIn(StretchIn), .ClockOut(ClockOut),
    .MidHighStrobe(MidHighStrobe), .MidLowStrobe(MidLowStrobe), .Running(Running),
    .ConfigError(ConfigError)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {28'd0, ClockOut, MidHighStrobe, MidLowStrobe, Running}, 32'b1000);
    chk({tag, "_err"}, {31'd0, ConfigError}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b0; StretchIn = 1'b1; BaudRate = 20'd0; ClockFrequency = 30'd0;
    step(2);
    chk_idle("reset");
    Reset = 1'b1;
    step(1);
    // CF=10, BR=2 -> Q=2, 30-cycle divide
    ClockFrequency = 30'd10; BaudRate = 20'd2; Enable = 1'b1;
    step(30);
    chk("q2_running_early", {31'd0, Running}, 32'd0);
    step(1);
    chk("q2_running", {31'd0, Running}, 32'd1);
    chk("q2_entry", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b100);
    step(1); chk("q2_k1", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b110);
    step(1); chk("q2_k2", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b000);
    step(1); chk("q2_k3", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b001);
    step(1); chk("q2_k4", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b100);
    step(1); chk("q2_k5", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe}, 32'b110);
    Enable = 1'b0;
    step(1);
    chk_idle("q2_stop");
    // CF=100, BR=5 -> Q=10, period 20
    ClockFrequency = 30'd100; BaudRate = 20'd5; Enable = 1'b1;
    step(31);
    chk("q10_running", {31'd0, Running}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk("q10_wave", {29'd0, ClockOut, MidHighStrobe, MidLowStrobe},
          {29'd0, ((k / 10) % 2) == 0, (k % 20) == 5, (k % 20) == 15});
    end
    step(12);
    chk("q10_lowphase", {31'd0, ClockOut}, 32'd0);
    Enable = 1'b0;
    step(1);
    chk_idle("run_abort");
    // zero baud rate
    BaudRate = 20'd0; Enable = 1'b1;
    step(1);
    chk("br0_err", {30'd0, ConfigError, Running}, 32'b10);
    step(3);
    chk("br0_sticky", {30'd0, ConfigError, Running}, 32'b10);
    Enable = 1'b0;
    step(1);
    chk("br0_clear", {31'd0, ConfigError}, 32'd0);
    // CF=3, BR=1 -> Q=1 invalid
    ClockFrequency = 30'd3; BaudRate = 20'd1; Enable = 1'b1;
    step(30);
    chk("q1_pending", {30'd0, ConfigError, Running}, 32'b00);
    step(1);
    chk("q1_err", {30'd0, ConfigError, Running}, 32'b10);
    step(5);
    chk("q1_sticky", {30'd0, ConfigError, Running}, 32'b10);
    Enable = 1'b0;
    step(1);
    chk("q1_clear", {31'd0, ConfigError}, 32'd0);
    // abort and reset mid-DIVIDE
    ClockFrequency = 30'd100; BaudRate = 20'd5; Enable = 1'b1;
    step(10);
    Enable = 1'b0;
    step(1);
    chk_idle("div_abort");
    Enable = 1'b1;
    step(5);
    Reset = 1'b0;
    step(1);
    chk_idle("div_reset");
    Reset = 1'b1;
    step(31);
    chk("restart_running", {31'd0, Running}, 32'd1);
    step(13);
    chk("rst_lowphase", {31'd0, ClockOut}, 32'd0);
    Reset = 1'b0;
    step(1);
    chk_idle("run_reset");
    Reset = 1'b1; Enable = 1'b0;
    step(1);
    // CF=1000, BR=7 -> Q=71
    ClockFrequency = 30'd1000; BaudRate = 20'd7; Enable = 1'b1;
    step(31);
    step(35);
    chk("q71_midhigh", {30'd0, ClockOut, MidHighStrobe}, 32'b11);
    step(35);
    chk("q71_high_end", {31'd0, ClockOut}, 32'd1);
    step(1);
    chk("q71_fall", {31'd0, ClockOut}, 32'd0);
    Enable = 1'b0;
    step(1);
    // stretch: StretchIn low across the first high-phase end
    ClockFrequency = 30'd100; BaudRate = 20'd5; Enable = 1'b1;
    step(31);
    for (int k = 1; k <= 43; k++) begin
      step(1);
      if (k == 5) StretchIn = 1'b0;
      if (k == 20) StretchIn = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
      chk("stretch_wave", {31'd0, ClockOut},
          {31'd0, k < 23 ? 1'b1 : (((k - 23) / 10) % 2) != 0});
`else
      chk("stretch_wave", {31'd0, ClockOut}, {31'd0, ((k / 10) % 2) == 0});
`endif
    end
    Enable = 1'b0;
    step(1);
    chk_idle("final_stop");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
